// File: rtl/lod_pkg.sv
// Shared constants and helpers for the pipelined leading-one detector.
// Group-level widths are fixed; W-dependent widths default to the 32-bit datapath.
package lod_pkg;

   localparam int unsigned GROUP_W    = 8;
   localparam int unsigned LOD_W      = 32;
   localparam int unsigned NUM_GROUPS = LOD_W / GROUP_W;
   localparam int unsigned POS_W      = $clog2(LOD_W);

   function automatic logic [2:0] hsb8(input logic [7:0] v);
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/lod_if.sv
// Request/result bundle for the leading-one detector.
interface lod_if #(
   parameter int unsigned W = 32
);
   logic                 valid_in;
   logic [W-1:0]         data_in;
   logic                 valid_out;
   logic [$clog2(W)-1:0] lod_pos;
   logic                 found;

   modport master (
      output valid_in, data_in,
      input  valid_out, lod_pos, found
   );

   modport slave (
      input  valid_in, data_in,
      output valid_out, lod_pos, found
   );
endinterface

// File: rtl/lod_group8.sv
// Combinational leading-one detector for one byte group.
module lod_group8
   import lod_pkg::*;
(
   input  logic [GROUP_W-1:0] din_i,
   output logic               nz_o,
   output logic [2:0]         idx_o
);

   assign nz_o  = |din_i;
   assign idx_o = hsb8(din_i);

endmodule

// File: rtl/lod.sv
// Two-stage leading-one detector: per-byte detection, then a priority select
// across the byte groups.
module lod
   import lod_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic clk,
   input  logic rst_n,
   lod_if.slave bus
);

   localparam int unsigned NG = W / GROUP_W;
   localparam int unsigned GW = $clog2(NG);
   localparam int unsigned PW = $clog2(W);

   logic [NG-1:0]      grp_nz;
   logic [NG-1:0][2:0] grp_idx;

   logic               s1_valid_d, s1_valid_q;
   logic [NG-1:0]      s1_nz_d, s1_nz_q;
   logic [NG-1:0][2:0] s1_idx_d, s1_idx_q;

   logic               out_valid_d, out_valid_q;
   logic [PW-1:0]      out_pos_d, out_pos_q;
   logic               out_found_d, out_found_q;

   logic [GW-1:0]      sel;

   for (genvar g = 0; g < NG; g++) begin : g_grp
      lod_group8 u_grp (
         .din_i (bus.data_in[g*GROUP_W +: GROUP_W]),
         .nz_o  (grp_nz[g]),
         .idx_o (grp_idx[g])
      );
   end

   always_comb begin
      s1_valid_d = bus.valid_in;
      s1_nz_d    = bus.valid_in ? grp_nz  : s1_nz_q;
      s1_idx_d   = bus.valid_in ? grp_idx : s1_idx_q;
   end

   // Highest-numbered non-empty group wins; empty word falls through to group 0.
   always_comb begin
      sel = '0;
      for (int g = 0; g < NG; g++) begin
         if (s1_nz_q[g]) sel = GW'(g);
      end
      out_valid_d = s1_valid_q;
      out_pos_d   = s1_valid_q ? {sel, s1_idx_q[sel]} : out_pos_q;
      out_found_d = s1_valid_q ? |s1_nz_q : out_found_q;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_nz_q     <= '0;
         s1_idx_q    <= '0;
         out_valid_q <= 1'b0;
         out_pos_q   <= '0;
         out_found_q <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_nz_q     <= s1_nz_d;
         s1_idx_q    <= s1_idx_d;
         out_valid_q <= out_valid_d;
         out_pos_q   <= out_pos_d;
         out_found_q <= out_found_d;
      end
   end

   assign bus.valid_out = out_valid_q;
   assign bus.lod_pos   = out_pos_q;
   assign bus.found     = out_found_q;

endmodule

// File: tb/tb_lod.sv
// Scoreboard bench for lod: expected results are queued on drive and
// compared when valid_out is seen.
module tb_lod;

   localparam int unsigned W = 32;

   typedef struct packed {
      logic       found;
      logic [4:0] pos;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   exp_t sb[$];
   logic m_v1, m_v2;

   lod_if #(.W(W)) bus ();

   lod #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t ref_model(input logic [31:0] d);
      exp_t e;
      e.found = 1'b0;
      e.pos   = '0;
      for (int i = 0; i < 32; i++) begin
         if (d[i]) begin
            e.found = 1'b1;
            e.pos   = 5'(i);
         end
      end
      return e;
   endfunction

   // Reference timing: valid_out is valid_in delayed by two edges, cleared by reset.
   always @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         m_v1 <= 1'b0;
         m_v2 <= 1'b0;
      end else begin
         m_v1 <= bus.valid_in;
         m_v2 <= m_v1;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      check("valid_out", 32'(bus.valid_out), 32'(m_v2));
      if (bus.valid_out === 1'b1) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("found", 32'(bus.found), 32'(e.found));
            check("lod_pos", 32'(bus.lod_pos), 32'(e.pos));
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] d);
      @(posedge clk);
      #1;
      bus.valid_in = v;
      bus.data_in  = d;
      if (v) sb.push_back(ref_model(d));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'hDEAD_BEEF);
   endtask

   logic [31:0] vec[$];

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst_n        = 1'b1;
      bus.valid_in = 1'b1;
      bus.data_in  = 32'h0000_0010;

      // Held reset with valid_in high: outputs stay cleared.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_valid", 32'(bus.valid_out), 32'd0);
         check("rst_pos", 32'(bus.lod_pos), 32'd0);
         check("rst_found", 32'(bus.found), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      bus.valid_in = 1'b0;
      drive(1'b1, 32'h0000_0010);

      vec = '{32'h0, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'h0001_0000,
              32'h80, 32'h100, 32'h0080_0000, 32'h0100_0000};
      foreach (vec[i]) begin
         drive(1'b1, vec[i]);
         drive(1'b0, 32'h0);
      end
      idle(2);

      // Back-to-back stream.
      drive(1'b1, 32'h1);
      drive(1'b1, 32'h3F);
      drive(1'b1, 32'h4000_0000);
      drive(1'b1, 32'h0);
      idle(3);

      // Bubbles hold the last result.
      drive(1'b1, 32'h0000_0200);
      for (int i = 0; i < 3; i++) drive(1'b0, 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(bus.valid_out), 32'd0);
         check("hold_pos", 32'(bus.lod_pos), 32'd9);
         check("hold_found", 32'(bus.found), 32'd1);
      end

      // Random words with occasional bubbles.
      for (int i = 0; i < 200; i++) begin
         logic [31:0] d;
         d = $urandom() >> $urandom_range(0, 31);
         if ($urandom_range(0, 15) == 0) d = 32'h0;
         drive(1'b1, d);
         if ($urandom_range(0, 3) == 0) drive(1'b0, $urandom());
      end
      idle(3);

      // Asynchronous reset with two words in flight.
      drive(1'b1, 32'h0000_4000);
      drive(1'b1, 32'h0200_0000);
      #3;
      bus.valid_in = 1'b0;
      rst_n        = 1'b1;
      sb.delete();
      #1;
      check("arst_valid", 32'(bus.valid_out), 32'd0);
      check("arst_pos", 32'(bus.lod_pos), 32'd0);
      check("arst_found", 32'(bus.found), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      idle(4);

      drive(1'b1, 32'h0000_0800);
      idle(3);
      check("sb_drain", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lod.md
# lod

Pipelined leading-one detector. It reports the bit index of the most-significant set bit of a W-bit word, plus a flag saying whether any bit was set. It sits in the GELU datapath's divider unit, where it normalises operands ahead of the reciprocal/shift logic. Results arrive with a fixed two-cycle latency.

## Interface
Parameters:
- W, 32, input word width; a power of two, at least 16.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous, active-high reset. Asserted when 1. The name is retained for codebase consistency.
- valid_in, input, 1, data_in is valid this cycle.
- data_in, input, W, word to scan.
- valid_out, output, 1, lod_pos and found are valid.
- lod_pos, output, $clog2(W), index of the highest set bit, counted from the LSB (bit 0).
- found, output, 1, 1 if data_in had at least one bit set.

## Operation
- found = OR-reduction of data_in.
- lod_pos = largest i with data_in[i] = 1.
- When data_in = 0: found = 0 and lod_pos = 0.
- Because lod_pos = 0 is ambiguous, consumers must qualify lod_pos with found.
- Stage 1, captured on a clk edge where valid_in = 1:
  - Split data_in into W/8 byte groups.
  - For each group, register a non-zero flag and the 3-bit local index of its highest set bit (0 if the group is empty).
- Stage 2:
  - Select the highest-numbered non-zero group g.
  - lod_pos = {g, local index of g}.
  - found = OR of all group flags.
  - If no group is non-zero: group index 0, local index 0.
- Stage data registers load only when their incoming valid bit is 1, so outputs hold their last result while the pipe is idle.
- valid registers load every cycle.
- No back-pressure. The block accepts one word per cycle indefinitely.

## Timing
- Latency: data presented with valid_in = 1 before rising edge N appears on lod_pos/found with valid_out = 1 after rising edge N+1.
- Throughput: one result per cycle.
- valid_out equals valid_in delayed by two rising edges.
- Reset (rst_n = 1, asynchronous):
  - All pipeline registers clear immediately: valid_out = 0, lod_pos = 0, found = 0.
  - They stay cleared while reset is held.
  - Words in flight are discarded; no valid_out pulses appear for them after release.
- First word sampled after reset release is the first word presented with valid_in = 1 at a rising edge where rst_n = 0.
- Back-to-back valid words produce back-to-back valid_out pulses, in order.
- Bubbles (valid_in = 0) produce matching bubbles on valid_out.
- Outputs change only on a clk edge or on reset assertion; no combinational input-to-output path.

## Structure
- Shared package (lod_pkg):
  - GROUP_W = 8.
  - NUM_GROUPS = W/8.
  - Position-width localparam $clog2(W).
  - Function returning the highest-set-bit index of an 8-bit value.
- One sub-module, lod_group8: purely combinational 8-bit leading-one detector with outputs nz and idx[2:0].
  - lod instantiates NUM_GROUPS copies in stage 1.
  - lod also uses a priority select over the group flags in stage 2.
- Registers: stage-1 flags/indices plus valid, and the stage-2 output registers.

## Test plan
- Reset: hold rst_n = 1 for 3 cycles with valid_in = 1 -> valid_out = 0, lod_pos = 0, found = 0 throughout. Deassert, drive 0x00000010 -> two edges later found = 1, lod_pos = 4.
- Edge values:
  - 0x00000000 -> found = 0, lod_pos = 0.
  - 0x80000000 -> found = 1, lod_pos = 31.
  - 0x00000001 -> found = 1, lod_pos = 0.
  - 0xFFFFFFFF -> lod_pos = 31.
  - 0x00010000 -> lod_pos = 16.
- Group boundaries: 0x00000080 -> 7; 0x00000100 -> 8; 0x00800000 -> 23; 0x01000000 -> 24.
- Streaming: valid_in = 1 for consecutive words 0x1, 0x3F, 0x40000000, 0x0 -> valid_out = 1 on four consecutive cycles, starting two edges after the first word, with lod_pos 0, 5, 30, 0 and found 1, 1, 1, 0.
- Bubbles and hold: word 0x00000200, then valid_in = 0 for 3 cycles with data_in = 0xFFFFFFFF -> one valid_out pulse with lod_pos = 9; afterwards valid_out = 0 while lod_pos stays 9 and found stays 1.
- Random and mid-stream reset:
  - 200 random words checked against a reference model (found = |din; lod_pos = highest set bit, or 0 if none).
  - Assert rst_n asynchronously between edges while two words are in flight -> outputs clear at once and no valid_out appears for those words.
